// File: rtl/whack_pkg.sv
// Shared phase codes, FSM encoding and LFSR taps for the whack-a-mole round engine
// and any future blocks that reuse the mole LFSR.
package whack_pkg;

   localparam logic [1:0] PH_WAIT = 2'b00;
   localparam logic [1:0] PH_PLAY = 2'b01;
   localparam logic [1:0] PH_OVER = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      UP,
      COOLDOWN,
      DONE
   } state_t;

   // x^8 + x^6 + x^5 + x^4 + 1 -> register bits 7, 5, 4, 3
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/whack_round_engine_if.sv
// Game-side bus of the round engine: phase code, tick, buttons in; mole, score and
// event pulses out.
interface whack_round_engine_if #(
   parameter int NUM_HOLES = 4,
   parameter int SCORE_W   = 8
);

   logic [1:0]           game_begin;
   logic                 tick;
   logic [NUM_HOLES-1:0] buttons;
   logic [NUM_HOLES-1:0] mole;
   logic [SCORE_W-1:0]   score;
   logic                 hit;
   logic                 miss;
   logic                 game_over;

   modport master (
      output game_begin, tick, buttons,
      input  mole, score, hit, miss, game_over
   );

   modport slave (
      input  game_begin, tick, buttons,
      output mole, score, hit, miss, game_over
   );

endinterface

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR that free-runs every cycle outside reset; used to pick holes
// and intended for reuse by sound/light blocks.
module mole_lfsr
   import whack_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] out
);

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= SEED;
      end else begin
         out <= {out[6:0], ^(out & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/whack_round_engine.sv
// Whack-a-mole round engine: follows the game phase code, pops moles at random holes,
// times them with tick and scores hits. Optional macro MISS_PENALTY_EN makes timeouts
// and wrong presses cost a point.
module whack_round_engine
   import whack_pkg::*;
#(
   parameter int         NUM_HOLES = 4,
   parameter int         UP_TICKS  = 3,
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         SCORE_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   whack_round_engine_if.slave  bus
);

   localparam int         IDX_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
   localparam logic [3:0] UP_T  = 4'(UP_TICKS);

   state_t               state, state_n;
   logic [NUM_HOLES-1:0] mole_r, mole_n;
   logic [NUM_HOLES-1:0] buttons_q, press;
   logic [SCORE_W-1:0]   score_r, score_n;
   logic [3:0]           timer, timer_n;
   logic                 hit_r, hit_n;
   logic                 miss_r, miss_n;
   logic                 over_r, over_n;
   logic [7:0]           lfsr;
   logic [IDX_W-1:0]     idx;
   logic                 lit_hit;
   logic                 wrong_press;
   logic                 timeout;
   logic                 lfsr_unused;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (&s) ? s : s + 1'b1;
   endfunction

`ifdef MISS_PENALTY_EN
   function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
      return (s == '0) ? s : s - 1'b1;
   endfunction
`endif

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .out   (lfsr)
   );

   assign idx         = lfsr[IDX_W-1:0];
   assign lfsr_unused = ^lfsr[7:IDX_W];

   assign press       = bus.buttons & ~buttons_q;
   assign lit_hit     = |(press & mole_r);
   assign wrong_press = |(press & ~mole_r);
   assign timeout     = bus.tick && (timer == 4'd1);

   always_comb begin
      state_n = state;
      mole_n  = mole_r;
      score_n = score_r;
      timer_n = timer;
      hit_n   = 1'b0;
      miss_n  = 1'b0;

      // A non-play phase aborts a running round before any hit/miss is considered.
      if ((state inside {PICK, UP, COOLDOWN}) && (bus.game_begin != PH_PLAY)) begin
         mole_n  = '0;
         state_n = (bus.game_begin == PH_WAIT) ? IDLE : DONE;
      end else begin
         unique case (state)
            IDLE: begin
               mole_n = '0;
               if (bus.game_begin == PH_PLAY) begin
                  state_n = PICK;
                  score_n = '0;
               end else if (bus.game_begin[1]) begin
                  state_n = DONE;
               end
            end
            PICK: begin
               mole_n  = NUM_HOLES'(1) << idx;
               timer_n = UP_T;
               state_n = UP;
            end
            UP: begin
               if (lit_hit) begin
                  score_n = sat_inc(score_r);
                  hit_n   = 1'b1;
                  mole_n  = '0;
                  state_n = COOLDOWN;
               end else begin
                  if (timeout) begin
                     miss_n  = 1'b1;
                     mole_n  = '0;
                     state_n = COOLDOWN;
                  end else if (bus.tick) begin
                     timer_n = timer - 4'd1;
                  end
`ifdef MISS_PENALTY_EN
                  if (timeout || wrong_press) begin
                     score_n = sat_dec(score_r);
                  end
`endif
               end
            end
            COOLDOWN: begin
               mole_n = '0;
               if (bus.tick) begin
                  state_n = PICK;
               end
            end
            DONE: begin
               mole_n = '0;
               if (bus.game_begin == PH_WAIT) begin
                  state_n = IDLE;
               end
            end
            default: begin
               mole_n  = '0;
               state_n = IDLE;
            end
         endcase
      end

      over_n = (state_n == DONE);
   end

   // Registered outputs: everything above becomes visible one cycle after the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mole_r    <= '0;
         score_r   <= '0;
         timer     <= '0;
         hit_r     <= 1'b0;
         miss_r    <= 1'b0;
         over_r    <= 1'b0;
         buttons_q <= '0;
      end else begin
         state     <= state_n;
         mole_r    <= mole_n;
         score_r   <= score_n;
         timer     <= timer_n;
         hit_r     <= hit_n;
         miss_r    <= miss_n;
         over_r    <= over_n;
         buttons_q <= bus.buttons;
      end
   end

   assign bus.mole      = mole_r;
   assign bus.score     = score_r;
   assign bus.hit       = hit_r;
   assign bus.miss      = miss_r;
   assign bus.game_over = over_r;

endmodule

// File: tb/tb_whack_round_engine.sv
// Self-checking bench for whack_round_engine: two instances (8-bit and 2-bit score)
// share stimulus; a table of per-cycle expectations drives a scoreboard queue.
module tb_whack_round_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] gb;
   logic       tk;
   logic [3:0] btn;

   always #5 clk = ~clk;

   whack_round_engine_if #(.NUM_HOLES(4), .SCORE_W(8)) bus8 ();
   whack_round_engine_if #(.NUM_HOLES(4), .SCORE_W(2)) bus2 ();

   assign bus8.game_begin = gb;
   assign bus8.tick       = tk;
   assign bus8.buttons    = btn;
   assign bus2.game_begin = gb;
   assign bus2.tick       = tk;
   assign bus2.buttons    = btn;

   whack_round_engine #(.NUM_HOLES(4), .UP_TICKS(3), .LFSR_SEED(8'hA5), .SCORE_W(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   whack_round_engine #(.NUM_HOLES(4), .UP_TICKS(3), .LFSR_SEED(8'hA5), .SCORE_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   // Reference LFSR; lfsr_prev holds the value that was current before the latest edge.
   logic [7:0] lfsr_m, lfsr_prev;
   always @(posedge clk) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      lfsr_prev <= lfsr_m;
   end

   typedef struct {
      logic [1:0] gb;
      logic       tk;
      int         mode;   // 0 none, 1 lit hole, 2 wrong hole, 3 both
      logic       lit;
      logic       hit;
      logic       miss;
      logic       over;
      int         score;
   } vec_t;

   typedef struct {
      logic lit;
      logic hit;
      logic miss;
      logic over;
      int   score;
      int   score2;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cur_hole = 0;
   logic prev_lit = 1'b0;
   int   s2       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] g, input logic t, input int m, input logic l,
                      input logic h, input logic ms, input logic o, input int s);
      vec_t v;
      v = '{g, t, m, l, h, ms, o, s};
      tbl.push_back(v);
   endtask

   task automatic run_row(input vec_t v, input string tag);
      exp_t       e;
      logic [3:0] litb, wrb;
      litb = 4'b0001 << cur_hole;
      wrb  = 4'b0001 << ((cur_hole + 1) % 4);
      gb   = v.gb;
      tk   = v.tk;
      case (v.mode)
         0:       btn = 4'b0000;
         1:       btn = litb;
         2:       btn = wrb;
         default: btn = litb | wrb;
      endcase
      if (v.hit)            s2 = (s2 < 3) ? s2 + 1 : 3;
      else if (v.score == 0) s2 = 0;
      e = '{v.lit, v.hit, v.miss, v.over, v.score, s2};
      sbq.push_back(e);

      @(posedge clk);
      #1;
      if (v.lit && !prev_lit) cur_hole = int'(lfsr_prev[1:0]);
      prev_lit = v.lit;

      e = sbq.pop_front();
      check({tag, " mole"},   32'(bus8.mole),      e.lit ? (32'd1 << cur_hole) : 32'd0);
      check({tag, " hit"},    32'(bus8.hit),       32'(e.hit));
      check({tag, " miss"},   32'(bus8.miss),      32'(e.miss));
      check({tag, " over"},   32'(bus8.game_over), 32'(e.over));
      check({tag, " score"},  32'(bus8.score),     32'(e.score));
      check({tag, " score2"}, 32'(bus2.score),     32'(e.score2));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " mole"},   32'(bus8.mole),      32'd0);
      check({tag, " score"},  32'(bus8.score),     32'd0);
      check({tag, " hit"},    32'(bus8.hit),       32'd0);
      check({tag, " miss"},   32'(bus8.miss),      32'd0);
      check({tag, " over"},   32'(bus8.game_over), 32'd0);
      check({tag, " score2"}, 32'(bus2.score),     32'd0);
      check({tag, " mole2"},  32'(bus2.mole),      32'd0);
   endtask

   initial begin
      vec_t v;

      //   gb     tk  mode lit hit miss over score
      add(2'b01, 0, 0, 0, 0, 0, 0, 0);  // IDLE -> PICK
      add(2'b01, 0, 0, 1, 0, 0, 0, 0);  // PICK -> UP, mole lit
      add(2'b01, 1, 0, 1, 0, 0, 0, 0);  // tick 1
      add(2'b01, 0, 0, 1, 0, 0, 0, 0);
      add(2'b01, 1, 0, 1, 0, 0, 0, 0);  // tick 2
      add(2'b01, 1, 0, 0, 0, 1, 0, 0);  // tick 3 -> miss
      add(2'b01, 0, 0, 0, 0, 0, 0, 0);  // cooldown waits for tick
      add(2'b01, 1, 0, 0, 0, 0, 0, 0);  // -> PICK
      add(2'b01, 0, 0, 1, 0, 0, 0, 0);  // UP
      add(2'b01, 1, 0, 1, 0, 0, 0, 0);  // one tick elapsed
      add(2'b01, 0, 1, 0, 1, 0, 0, 1);  // press lit -> hit
      add(2'b01, 0, 1, 0, 0, 0, 0, 1);  // held press, no second hit
      add(2'b01, 1, 0, 0, 0, 0, 0, 1);  // -> PICK
      add(2'b01, 0, 0, 1, 0, 0, 0, 1);  // UP
      add(2'b01, 1, 0, 1, 0, 0, 0, 1);
      add(2'b01, 1, 0, 1, 0, 0, 0, 1);
      add(2'b01, 1, 1, 0, 1, 0, 0, 2);  // press + final tick -> hit only
      add(2'b01, 1, 0, 0, 0, 0, 0, 2);  // -> PICK
      add(2'b01, 0, 0, 1, 0, 0, 0, 2);  // UP
      add(2'b01, 0, 2, 1, 0, 0, 0, 2);  // wrong hole ignored
      add(2'b01, 0, 3, 0, 1, 0, 0, 3);  // lit pressed while wrong held -> hit
      add(2'b01, 0, 3, 0, 0, 0, 0, 3);  // both held
      add(2'b01, 1, 3, 0, 0, 0, 0, 3);  // -> PICK
      add(2'b01, 0, 0, 1, 0, 0, 0, 3);  // UP
      add(2'b01, 0, 1, 0, 1, 0, 0, 4);  // hit 4
      add(2'b01, 1, 0, 0, 0, 0, 0, 4);
      add(2'b01, 0, 0, 1, 0, 0, 0, 4);
      add(2'b01, 0, 1, 0, 1, 0, 0, 5);  // hit 5
      add(2'b01, 1, 0, 0, 0, 0, 0, 5);
      add(2'b01, 0, 0, 1, 0, 0, 0, 5);  // UP
      add(2'b10, 1, 1, 0, 0, 0, 1, 5);  // over beats hit and tick
      add(2'b10, 0, 0, 0, 0, 0, 1, 5);
      add(2'b00, 0, 0, 0, 0, 0, 0, 5);  // DONE -> IDLE, score held
      add(2'b01, 0, 0, 0, 0, 0, 0, 0);  // IDLE -> PICK clears score
      add(2'b01, 0, 0, 1, 0, 0, 0, 0);  // UP
      add(2'b00, 0, 0, 0, 0, 0, 0, 0);  // wait phase aborts round
      add(2'b11, 0, 0, 0, 0, 0, 1, 0);  // reserved code acts as over
      add(2'b00, 0, 0, 0, 0, 0, 0, 0);  // back to IDLE

      reset = 1'b1;
      gb    = 2'b00;
      tk    = 1'b0;
      btn   = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         run_row(tbl[i], $sformatf("row%0d", i));
      end

      // Reset in the middle of a round, coinciding with a hit and a tick.
      v = '{2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "mg_pick");
      v = '{2'b01, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "mg_up");
      v = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      run_row(v, "mg_hit");
      v = '{2'b01, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      run_row(v, "mg_pick2");
      v = '{2'b01, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      run_row(v, "mg_up2");

      reset = 1'b1;
      tk    = 1'b1;
      btn   = 4'b0001 << cur_hole;
      @(posedge clk);
      #1;
      check_reset_state("midreset");
      reset    = 1'b0;
      tk       = 1'b0;
      btn      = 4'b0000;
      s2       = 0;
      prev_lit = 1'b0;

      v = '{2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "post_pick");
      v = '{2'b01, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "post_up");
      v = '{2'b01, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "post_t1");
      v = '{2'b01, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      run_row(v, "post_t2");
      v = '{2'b01, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      run_row(v, "post_miss");

      check("scoreboard empty", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
